// File: rtl/dfi_lpddr4_responder_if.sv
// dfi_lpddr4_responder_if: 4-phase LPDDR4 DFI command and read-data bus between controller and PHY responder
interface dfi_lpddr4_responder_if;
  logic [3:0] dfi_cs;
  logic [23:0] dfi_ca;
  logic [3:0] dfi_rddata_en;
  logic [255:0] dfi_rddata;
  logic [3:0] dfi_rddata_valid;
  modport master (output dfi_cs, dfi_ca, dfi_rddata_en, input dfi_rddata, dfi_rddata_valid);
  modport slave (input dfi_cs, dfi_ca, dfi_rddata_en, output dfi_rddata, dfi_rddata_valid);
endinterface

// File: rtl/dfi_lpddr4_responder.sv
// dfi_lpddr4_responder: LPDDR4 DFI command decoder, bank tracker and fixed-latency read-data returner.
// Optional: define DFI_RESP_CHECK_EN to flag bank-state access violations on err_sticky[2].
module dfi_lpddr4_responder #(
  parameter int RD_LAT = 4,
  parameter int NUM_BANKS = 8
) (
  input  logic sys_clk,
  input  logic sys_rst,
  dfi_lpddr4_responder_if.slave dfi,
  output logic cmd_a_valid,
  output logic [2:0] cmd_a_type,
  output logic [2:0] cmd_a_bank,
  output logic [1:0] cmd_a_phase,
  output logic cmd_b_valid,
  output logic [2:0] cmd_b_type,
  output logic [2:0] cmd_b_bank,
  output logic [1:0] cmd_b_phase,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic [2:0] err_sticky,
  input  logic err_clr
);
  typedef enum logic [1:0] {IDLE, EDGE2, WAITPAIR, PAIR2} state_t;
  state_t st, s;
  logic [2:0] typ, t, bank, b, err_n;
  logic [NUM_BANKS-1:0] bo;
  logic cs, done, pair, n;
  logic [5:0] ca;
  logic av, bv;
  logic [2:0] at, ab, bt, bb;
  logic [1:0] ap, bp;
  logic [3:0] pipe [RD_LAT];
  logic [31:0] beat_cnt, c;
  logic [255:0] rd;
  // Pending command type: 0 marks an unknown 2-edge command that is never reported
  function automatic logic [2:0] first_type(input logic [5:0] x);
    return x[0] ? (x[1] ? 3'd0 : 3'd1) :
           x[4:0] == 5'b00010 ? 3'd2 :
           x[4:0] == 5'b00100 ? 3'd3 :
           x[4:0] == 5'b01100 ? 3'd4 :
           x[4:0] == 5'b10000 ? (x[5] ? 3'd6 : 3'd5) :
           x[4:0] == 5'b01000 ? 3'd7 : 3'd0;
  endfunction
  always_comb begin
    s = st; t = typ; b = bank; bo = bank_open; err_n = '0; n = 1'b0;
    cs = 1'b0; ca = '0; done = 1'b0; pair = 1'b0;
    av = 1'b0; at = '0; ab = '0; ap = '0; bv = 1'b0; bt = '0; bb = '0; bp = '0;
    for (int p = 0; p < 4; p++) begin
      cs = dfi.dfi_cs[p];
      ca = dfi.dfi_ca[6*p +: 6];
      pair = (s == WAITPAIR) && (t == 3'd1 ? ca[1:0] == 2'b11 : ca[4:0] == 5'b10010);
      done = !cs && (s == PAIR2 || (s == EDGE2 && t >= 3'd5));
      if (cs) begin
        err_n[1] = err_n[1] | (s == EDGE2) | (s == PAIR2);
        err_n[0] = err_n[0] | ((s == WAITPAIR) && !pair);
        t = pair ? t : first_type(ca);
        s = pair ? PAIR2 : EDGE2;
      end else if (s == EDGE2) begin
        b = ca[2:0];
        s = (t == 3'd0 || t >= 3'd5) ? IDLE : WAITPAIR;
      end else if (s == PAIR2)
        s = IDLE;
      if (done) begin
`ifdef DFI_RESP_CHECK_EN
        if (t == 3'd1 ? bo[b] : (t <= 3'd4 && !bo[b])) err_n[2] = 1'b1;
`endif
        if (t == 3'd1) bo[b] = 1'b1;
        else if (t == 3'd5) bo[b] = 1'b0;
        else if (t == 3'd6) bo = '0;
        if (n) begin
          bv = 1'b1; bt = t; bb = t == 3'd7 ? 3'd0 : b; bp = 2'(p);
        end else begin
          av = 1'b1; at = t; ab = t == 3'd7 ? 3'd0 : b; ap = 2'(p);
        end
        n = 1'b1;
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st <= IDLE; typ <= '0; bank <= '0; bank_open <= '0; err_sticky <= '0;
      cmd_a_valid <= 1'b0; cmd_a_type <= '0; cmd_a_bank <= '0; cmd_a_phase <= '0;
      cmd_b_valid <= 1'b0; cmd_b_type <= '0; cmd_b_bank <= '0; cmd_b_phase <= '0;
    end else begin
      st <= s; typ <= t; bank <= b; bank_open <= bo;
      err_sticky <= (err_clr ? 3'b0 : err_sticky) | err_n;
      cmd_a_valid <= av; cmd_a_type <= at; cmd_a_bank <= ab; cmd_a_phase <= ap;
      cmd_b_valid <= bv; cmd_b_type <= bt; cmd_b_bank <= bb; cmd_b_phase <= bp;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      beat_cnt <= '0;
    end else begin
      pipe[0] <= dfi.dfi_rddata_en;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      beat_cnt <= beat_cnt + 32'($countones(pipe[RD_LAT-1]));
    end
  end
  // Beats are numbered in phase order starting from the running counter
  always_comb begin
    c = beat_cnt; rd = '0;
    for (int p = 0; p < 4; p++)
      if (pipe[RD_LAT-1][p]) begin
        rd[64*p +: 64] = {c, ~c};
        c = c + 32'd1;
      end
  end
  assign dfi.dfi_rddata = rd;
  assign dfi.dfi_rddata_valid = pipe[RD_LAT-1];
endmodule

// File: tb/tb_dfi_lpddr4_responder.sv
// tb_dfi_lpddr4_responder: command-level generator with expected reports, bank/error and read-return model
module tb_dfi_lpddr4_responder;
  localparam int RD_LAT = 4;
  logic sys_clk = 1'b0, sys_rst, err_clr;
  always #5 sys_clk = ~sys_clk;
  dfi_lpddr4_responder_if dfi();
  logic cmd_a_valid, cmd_b_valid;
  logic [2:0] cmd_a_type, cmd_a_bank, cmd_b_type, cmd_b_bank, err_sticky;
  logic [1:0] cmd_a_phase, cmd_b_phase;
  logic [7:0] bank_open;
  dfi_lpddr4_responder #(.RD_LAT(RD_LAT), .NUM_BANKS(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .dfi(dfi),
    .cmd_a_valid(cmd_a_valid), .cmd_a_type(cmd_a_type), .cmd_a_bank(cmd_a_bank), .cmd_a_phase(cmd_a_phase),
    .cmd_b_valid(cmd_b_valid), .cmd_b_type(cmd_b_type), .cmd_b_bank(cmd_b_bank), .cmd_b_phase(cmd_b_phase),
    .bank_open(bank_open), .err_sticky(err_sticky), .err_clr(err_clr)
  );
  typedef struct { logic cs; logic [5:0] ca; int ty; int bk; logic [2:0] er; } ph_t;
  ph_t q[$];
  logic [3:0] en_q[$];
  logic [7:0] m_open;
  logic [2:0] m_err;
  logic [31:0] m_beat;
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction
  task automatic push(input logic cs, input logic [5:0] ca, input int ty, input int bk, input logic [2:0] er);
    ph_t e;
    e.cs = cs; e.ca = ca; e.ty = ty; e.bk = bk; e.er = er;
    q.push_back(e);
  endtask
  task automatic lo();
    push(1'b0, r6(), 0, 0, 3'b0);
  endtask
  task automatic act(input int bk, input int gap);
    push(1'b1, {4'($urandom), 2'b01}, 0, 0, 3'b0);
    push(1'b0, {3'($urandom), 3'(bk)}, 0, 0, 3'b0);
    repeat (gap) lo();
    push(1'b1, {4'($urandom), 2'b11}, 0, 0, 3'b0);
    push(1'b0, r6(), 1, bk, 3'b0);
  endtask
  task automatic cas(input int ty, input int bk, input int gap);
    logic [4:0] code;
    code = ty == 2 ? 5'b00010 : ty == 3 ? 5'b00100 : 5'b01100;
    push(1'b1, {1'($urandom), code}, 0, 0, 3'b0);
    push(1'b0, {3'($urandom), 3'(bk)}, 0, 0, 3'b0);
    repeat (gap) lo();
    push(1'b1, {1'($urandom), 5'b10010}, 0, 0, 3'b0);
    push(1'b0, r6(), ty, bk, 3'b0);
  endtask
  task automatic pre(input int bk, input logic all);
    push(1'b1, {all, 5'b10000}, 0, 0, 3'b0);
    push(1'b0, {3'($urandom), 3'(bk)}, all ? 6 : 5, bk, 3'b0);
  endtask
  task automatic ref_cmd();
    push(1'b1, {1'($urandom), 5'b01000}, 0, 0, 3'b0);
    push(1'b0, r6(), 7, 0, 3'b0);
  endtask
  task automatic unk();
    logic [4:0] c;
    do c = 5'($urandom) & 5'b11110;
    while (c == 5'b00010 || c == 5'b00100 || c == 5'b01100 || c == 5'b10000 || c == 5'b01000);
    push(1'b1, {1'($urandom), c}, 0, 0, 3'b0);
    push(1'b0, r6(), 0, 0, 3'b0);
  endtask
  task automatic gen_rand();
    int k, bk;
    k = $urandom_range(0, 7);
    bk = $urandom_range(0, 7);
    repeat ($urandom_range(0, 2)) lo();
    if (k == 0) act(bk, $urandom_range(0, 3));
    else if (k <= 3) cas(k + 1, bk, $urandom_range(0, 3));
    else if (k == 4) pre(bk, 1'b0);
    else if (k == 5) pre(bk, 1'b1);
    else if (k == 6) ref_cmd();
    else unk();
  endtask
  task automatic do_reset();
    sys_rst = 1'b1; err_clr = 1'b0;
    dfi.dfi_cs = '0; dfi.dfi_ca = '0; dfi.dfi_rddata_en = '0;
    q.delete(); en_q.delete();
    repeat (RD_LAT - 1) en_q.push_back(4'b0);
    m_open = '0; m_err = '0; m_beat = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_a_valid", 256'(cmd_a_valid), 256'(0));
    chk("rst_b_valid", 256'(cmd_b_valid), 256'(0));
    chk("rst_bank_open", 256'(bank_open), 256'(0));
    chk("rst_err", 256'(err_sticky), 256'(0));
    chk("rst_rd_valid", 256'(dfi.dfi_rddata_valid), 256'(0));
    chk("rst_rd_data", dfi.dfi_rddata, 256'(0));
    sys_rst = 1'b0;
  endtask
  task automatic step(input logic [3:0] en, input logic clr);
    ph_t e;
    logic [2:0] ne;
    logic [1:0] ev;
    int et[2], eb[2], ep[2];
    int n;
    logic [3:0] vr;
    logic [255:0] ed;
    ne = '0; ev = '0; n = 0;
    et = '{0, 0}; eb = '{0, 0}; ep = '{0, 0};
    for (int p = 0; p < 4; p++) begin
      if (q.size() > 0) e = q.pop_front();
      else begin
        e.cs = 1'b0; e.ca = r6(); e.ty = 0; e.bk = 0; e.er = '0;
      end
      dfi.dfi_cs[p] = e.cs;
      dfi.dfi_ca[6*p +: 6] = e.ca;
      ne = ne | e.er;
      if (e.ty != 0 && n < 2) begin
        ev[n] = 1'b1; et[n] = e.ty; eb[n] = e.bk; ep[n] = p;
        n++;
`ifdef DFI_RESP_CHECK_EN
        if ((e.ty == 1 && m_open[e.bk]) || (e.ty >= 2 && e.ty <= 4 && !m_open[e.bk])) ne[2] = 1'b1;
`endif
        if (e.ty == 1) m_open[e.bk] = 1'b1;
        else if (e.ty == 5) m_open[e.bk] = 1'b0;
        else if (e.ty == 6) m_open = '0;
      end
    end
    dfi.dfi_rddata_en = en;
    err_clr = clr;
    en_q.push_back(en);
    m_err = (clr ? 3'b0 : m_err) | ne;
    @(posedge sys_clk);
    #1;
    chk("a_valid", 256'(cmd_a_valid), 256'(ev[0]));
    if (ev[0]) begin
      chk("a_type", 256'(cmd_a_type), 256'(et[0]));
      chk("a_bank", 256'(cmd_a_bank), 256'(eb[0]));
      chk("a_phase", 256'(cmd_a_phase), 256'(ep[0]));
    end
    chk("b_valid", 256'(cmd_b_valid), 256'(ev[1]));
    if (ev[1]) begin
      chk("b_type", 256'(cmd_b_type), 256'(et[1]));
      chk("b_bank", 256'(cmd_b_bank), 256'(eb[1]));
      chk("b_phase", 256'(cmd_b_phase), 256'(ep[1]));
    end
    chk("bank_open", 256'(bank_open), 256'(m_open));
    chk("err_sticky", 256'(err_sticky), 256'(m_err));
    vr = en_q.pop_front();
    ed = '0;
    for (int p = 0; p < 4; p++)
      if (vr[p]) begin
        ed[64*p +: 64] = {m_beat, ~m_beat};
        m_beat = m_beat + 32'd1;
      end
    chk("rd_valid", 256'(dfi.dfi_rddata_valid), 256'(vr));
    chk("rd_data", dfi.dfi_rddata, ed);
  endtask
  initial begin
    do_reset();
    act(5, 0);
    step(4'b0, 1'b0);
    step(4'b0, 1'b0);
    lo(); lo();
    push(1'b1, {1'($urandom), 5'b00010}, 0, 0, 3'b0);
    push(1'b0, {3'($urandom), 3'd5}, 0, 0, 3'b0);
    step(4'b0, 1'b0);
    push(1'b1, {1'($urandom), 5'b10010}, 0, 0, 3'b0);
    push(1'b0, r6(), 2, 5, 3'b0);
    step(4'b0, 1'b0);
    act(1, 0);
    step(4'b0, 1'b0);
    pre(1, 1'b0);
    ref_cmd();
    step(4'b0, 1'b0);
    push(1'b1, {1'($urandom), 5'b00010}, 0, 0, 3'b0);
    push(1'b0, {3'($urandom), 3'd5}, 0, 0, 3'b0);
    push(1'b1, {1'b0, 5'b10000}, 0, 0, 3'b001);
    push(1'b0, {3'($urandom), 3'd2}, 5, 2, 3'b0);
    step(4'b0, 1'b0);
    step(4'b0, 1'b1);
    push(1'b1, {4'($urandom), 2'b01}, 0, 0, 3'b0);
    push(1'b1, {1'($urandom), 5'b01000}, 0, 0, 3'b010);
    push(1'b0, r6(), 7, 0, 3'b0);
    step(4'b0, 1'b0);
    step(4'b0, 1'b1);
    step(4'b1010, 1'b0);
    repeat (RD_LAT) step(4'b0, 1'b0);
    cas(2, 3, 1);
    step(4'b0, 1'b0);
    step(4'b0, 1'b0);
    step(4'b0, 1'b1);
    push(1'b1, {4'($urandom), 2'b01}, 0, 0, 3'b0);
    push(1'b0, {3'($urandom), 3'd4}, 0, 0, 3'b0);
    step(4'b0, 1'b0);
    do_reset();
    push(1'b1, {4'($urandom), 2'b11}, 0, 0, 3'b0);
    push(1'b0, r6(), 0, 0, 3'b0);
    step(4'b0, 1'b0);
    step(4'b0, 1'b0);
    repeat (300) begin
      if (q.size() < 8) gen_rand();
      step(4'($urandom), $urandom_range(0, 9) == 0);
    end
    repeat (8) step(4'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
